// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded register file slice.
//   DEF_W       : default data width in bits
//   DEF_A       : default address width (depth is 2**A)
//   DEF_IMM_REG : default destination register of immediate loads
//   sbState_t   : load scoreboard state (IDLE = nothing outstanding,
//                 PEND = one load in flight to the pending destination)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_A       = 4;
  localparam int DEF_IMM_REG = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } sbState_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Tracks a single outstanding memory load and flags hazards against it.
// Parameters:
//   A, IMM_REG  : address width and fixed immediate destination register
// Ports:
//   Clk, Reset        : rising-edge clock, synchronous active-high reset
//   ldIssue_i/ldDst_i : load issue request and its destination register
//   ldValid_i         : memory return strobe
//   raddrA_i/raddrB_i : read addresses checked against the pending register
//   writeEn_i/waddr_i : ALU write request
//   immEn_i           : immediate write request (always targets IMM_REG)
//   copyEn_i/copySrc_i/copyDst_i : register move request
//   busy_o            : a load is outstanding
//   stall_o           : current requests touch the pending register
//   ldCommit_o        : the memory return writes pdst_o on this edge
//   pdst_o            : pending destination register
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int A       = DEF_A,
  parameter int IMM_REG = DEF_IMM_REG
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ldIssue_i,
  input  logic [A-1:0] ldDst_i,
  input  logic         ldValid_i,
  input  logic [A-1:0] raddrA_i,
  input  logic [A-1:0] raddrB_i,
  input  logic         writeEn_i,
  input  logic [A-1:0] waddr_i,
  input  logic         immEn_i,
  input  logic         copyEn_i,
  input  logic [A-1:0] copySrc_i,
  input  logic [A-1:0] copyDst_i,
  output logic         busy_o,
  output logic         stall_o,
  output logic         ldCommit_o,
  output logic [A-1:0] pdst_o
);

  localparam logic [A-1:0] ImmAddr = A'(IMM_REG);

  sbState_t     state_q, state_d;
  logic [A-1:0] pdst_q, pdst_d;
  logic         hazard;

  // State and pending-destination registers; reset abandons any load in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pdst_q  <= '0;
    end else begin
      state_q <= state_d;
      pdst_q  <= pdst_d;
    end
  end

  // Next-state and output decode. A return in PEND clears every hazard for
  // that cycle, which is also what lets a new issue be accepted alongside it
  // and keep the scoreboard in PEND with the new destination.
  always_comb begin
    state_d    = state_q;
    pdst_d     = pdst_q;
    busy_o     = 1'b0;
    stall_o    = 1'b0;
    ldCommit_o = 1'b0;
    hazard     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ldIssue_i) begin
          state_d = PEND;
          pdst_d  = ldDst_i;
        end
      end
      PEND: begin
        busy_o = 1'b1;
        hazard = (raddrA_i == pdst_q) | (raddrB_i == pdst_q) |
                 (writeEn_i & (waddr_i == pdst_q)) |
                 (copyEn_i & ((copySrc_i == pdst_q) | (copyDst_i == pdst_q))) |
                 (immEn_i & (ImmAddr == pdst_q)) |
                 ldIssue_i;
        stall_o = hazard & ~ldValid_i;
        if (ldValid_i) begin
          ldCommit_o = 1'b1;
          if (ldIssue_i) begin
            pdst_d = ldDst_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pdst_o = pdst_q;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// 2**A x W register file with two combinational read ports, an ALU write
// port, an immediate write to IMM_REG, a register move and a scoreboarded
// memory load port.
// Parameters:
//   W, A, IMM_REG : data width, address width, immediate destination
//   ZERO_R0       : when 1, r0 reads as zero and ignores all writes
// Ports:
//   Clk, Reset              : rising-edge clock, synchronous active-high reset
//   RaddrA/RaddrB           : read addresses; DataOutA/DataOutB read data
//   WriteEn/Waddr/DataIn    : ALU write
//   ImmEn/ImmData           : immediate write to IMM_REG
//   CopyEn/CopySrc/CopyDst  : register move (source sampled before the edge)
//   LdIssue/LdDst           : load issue
//   LdValid/LdData          : memory return
//   Busy                    : a load is outstanding
//   Stall                   : request hazards on the pending register
// Build option:
//   REGFILE_BYPASS_EN : when defined, read ports see the priority-resolved
//                       write data of the current cycle for a matching
//                       address; otherwise reads return the stored value.
// ---------------------------------------------------------------------------
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int A       = DEF_A,
  parameter int IMM_REG = DEF_IMM_REG,
  parameter int ZERO_R0 = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         WriteEn,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic         ImmEn,
  input  logic [W-1:0] ImmData,
  input  logic         CopyEn,
  input  logic [A-1:0] CopySrc,
  input  logic [A-1:0] CopyDst,
  input  logic         LdIssue,
  input  logic [A-1:0] LdDst,
  input  logic         LdValid,
  input  logic [W-1:0] LdData,
  output logic         Busy,
  output logic         Stall
);

  localparam int           DEPTH   = 2 ** A;
  localparam logic [A-1:0] ImmAddr = A'(IMM_REG);

  logic [W-1:0] regs_q [DEPTH];
  logic [W-1:0] regs_d [DEPTH];

  logic         ldCommit;
  logic [A-1:0] pdst;
  logic         weEff;
  logic         immEff;
  logic         copyEff;
  logic [W-1:0] copyData;

  // Load scoreboard: decides when the memory return commits and which
  // requests must be held back this cycle.
  regfile_scoreboard #(
    .A       (A),
    .IMM_REG (IMM_REG)
  ) u_scoreboard (
    .Clk        (Clk),
    .Reset      (Reset),
    .ldIssue_i  (LdIssue),
    .ldDst_i    (LdDst),
    .ldValid_i  (LdValid),
    .raddrA_i   (RaddrA),
    .raddrB_i   (RaddrB),
    .writeEn_i  (WriteEn),
    .waddr_i    (Waddr),
    .immEn_i    (ImmEn),
    .copyEn_i   (CopyEn),
    .copySrc_i  (CopySrc),
    .copyDst_i  (CopyDst),
    .busy_o     (Busy),
    .stall_o    (Stall),
    .ldCommit_o (ldCommit),
    .pdst_o     (pdst)
  );

  // Stalled requests are dropped; the load return is never suppressed.
  assign weEff   = WriteEn & ~Stall;
  assign immEff  = ImmEn & ~Stall;
  assign copyEff = CopyEn & ~Stall;

  // The move source is the stored value from before the edge.
  assign copyData = ((ZERO_R0 != 0) && (CopySrc == '0)) ? '0 : regs_q[CopySrc];

  // Next-value computation. Writes are applied lowest priority first so a
  // higher-priority source to the same register overrides it, while writes
  // to different registers all land. r0 is pinned last when hard-wired, which
  // also discards a load return aimed at it.
  always_comb begin
    regs_d = regs_q;
    if (weEff) begin
      regs_d[Waddr] = DataIn;
    end
    if (copyEff) begin
      regs_d[CopyDst] = copyData;
    end
    if (immEff) begin
      regs_d[ImmAddr] = ImmData;
    end
    if (ldCommit) begin
      regs_d[pdst] = LdData;
    end
    if (ZERO_R0 != 0) begin
      regs_d[0] = '0;
    end
  end

  // Storage; reset wins over every write in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // regs_d already holds the priority-resolved value of every register,
  // so reading it forwards same-cycle write data.
  assign DataOutA = regs_d[RaddrA];
  assign DataOutB = regs_d[RaddrB];
`else
  assign DataOutA = ((ZERO_R0 != 0) && (RaddrA == '0)) ? '0 : regs_q[RaddrA];
  assign DataOutB = ((ZERO_R0 != 0) && (RaddrB == '0)) ? '0 : regs_q[RaddrB];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. dut0 uses ZERO_R0=0, dut1 uses ZERO_R0=1;
// both see the same stimulus. Each step drives inputs after the falling edge
// and checks the combinational outputs just before the next rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] RaddrA, RaddrB, Waddr, CopySrc, CopyDst, LdDst;
  logic [7:0] DataIn, ImmData, LdData;
  logic       WriteEn, ImmEn, CopyEn, LdIssue, LdValid;
  logic [7:0] outA0, outB0, outA1, outB1;
  logic       busy0, stall0, busy1, stall1;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 Clk = ~Clk;

  reg_file_sb #(.W(8), .A(4), .IMM_REG(3), .ZERO_R0(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(outA0), .DataOutB(outB0),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .ImmEn(ImmEn), .ImmData(ImmData),
    .CopyEn(CopyEn), .CopySrc(CopySrc), .CopyDst(CopyDst),
    .LdIssue(LdIssue), .LdDst(LdDst), .LdValid(LdValid), .LdData(LdData),
    .Busy(busy0), .Stall(stall0)
  );

  reg_file_sb #(.W(8), .A(4), .IMM_REG(3), .ZERO_R0(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(outA1), .DataOutB(outB1),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .ImmEn(ImmEn), .ImmData(ImmData),
    .CopyEn(CopyEn), .CopySrc(CopySrc), .CopyDst(CopyDst),
    .LdIssue(LdIssue), .LdDst(LdDst), .LdValid(LdValid), .LdData(LdData),
    .Busy(busy1), .Stall(stall1)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       im;
    logic [7:0] imd;
    logic       cp;
    logic [3:0] cs;
    logic [3:0] cd;
    logic       li;
    logic [3:0] ld;
    logic       lv;
    logic [7:0] lvd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] expA;
    logic [7:0] expB;
    logic       expBusy;
    logic       expStall;
  } vec_t;

  // Argument order: name, we,wa,wd, im,imd, cp,cs,cd, li,ld, lv,lvd, ra,rb, expA,expB,expBusy,expStall
  function automatic vec_t mk(input string n,
                              input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic im, input logic [7:0] imd,
                              input logic cp, input logic [3:0] cs, input logic [3:0] cd,
                              input logic li, input logic [3:0] ld,
                              input logic lv, input logic [7:0] lvd,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [7:0] ea, input logic [7:0] eb,
                              input logic eBusy, input logic eStall);
    vec_t v;
    v.name = n; v.rst = 1'b0;
    v.we = we; v.wa = wa; v.wd = wd;
    v.im = im; v.imd = imd;
    v.cp = cp; v.cs = cs; v.cd = cd;
    v.li = li; v.ld = ld;
    v.lv = lv; v.lvd = lvd;
    v.ra = ra; v.rb = rb;
    v.expA = ea; v.expB = eb; v.expBusy = eBusy; v.expStall = eStall;
    return v;
  endfunction

  function automatic vec_t idleVec(input string n);
    return mk(n, 0, 4'd0, 8'h00, 0, 8'h00, 0, 4'd0, 4'd0, 0, 4'd0, 0, 8'h00,
              4'd0, 4'd0, 8'h00, 8'h00, 0, 0);
  endfunction

  // Drive one cycle of inputs after the falling edge, then settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge Clk);
    Reset   = v.rst;
    WriteEn = v.we;  Waddr   = v.wa;  DataIn  = v.wd;
    ImmEn   = v.im;  ImmData = v.imd;
    CopyEn  = v.cp;  CopySrc = v.cs;  CopyDst = v.cd;
    LdIssue = v.li;  LdDst   = v.ld;
    LdValid = v.lv;  LdData  = v.lvd;
    RaddrA  = v.ra;  RaddrB  = v.rb;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic checkAll0(input vec_t v);
    checkOutput({v.name, ".A"}, outA0, v.expA);
    checkOutput({v.name, ".B"}, outB0, v.expB);
    checkOutput({v.name, ".Busy"}, {7'd0, busy0}, {7'd0, v.expBusy});
    checkOutput({v.name, ".Stall"}, {7'd0, stall0}, {7'd0, v.expStall});
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    // Main flow, one row per cycle, expectations are pre-edge outputs.
    vecs.push_back(mk("rstState",    0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd5,4'd0, 8'h00,8'h00,0,0));
    vecs.push_back(mk("wr5",         1,4'd5,8'hA5, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd6,4'd0, 8'h00,8'h00,0,0));
    vecs.push_back(mk("rd5",         0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd5,4'd0, 8'hA5,8'h00,0,0));
    vecs.push_back(mk("immVsWe",     1,4'd3,8'h11, 1,8'h3C, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd5,4'd1, 8'hA5,8'h00,0,0));
    vecs.push_back(mk("copy31",      0,4'd0,8'h00, 0,8'h00, 1,4'd3,4'd1, 0,4'd0, 0,8'h00, 4'd3,4'd5, 8'h3C,8'hA5,0,0));
    vecs.push_back(mk("issue7",      0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 1,4'd7, 0,8'h00, 4'd1,4'd3, 8'h3C,8'h3C,0,0));
    vecs.push_back(mk("stallRd7",    1,4'd2,8'h99, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd7,4'd1, 8'h00,8'h3C,1,1));
    vecs.push_back(mk("ret7",        0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 1,8'h5E, 4'd2,4'd0, 8'h00,8'h00,1,0));
    vecs.push_back(mk("reissue7",    0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 1,4'd7, 0,8'h00, 4'd7,4'd2, 8'h5E,8'h00,0,0));
    vecs.push_back(mk("retIssue2",   0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 1,4'd2, 1,8'hC4, 4'd5,4'd3, 8'hA5,8'h3C,1,0));
    vecs.push_back(mk("pend2RdB",    0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd7,4'd2, 8'hC4,8'h00,1,1));
    vecs.push_back(mk("weHaz2",      1,4'd2,8'hEE, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd7,4'd5, 8'hC4,8'hA5,1,1));
    vecs.push_back(mk("cpHaz2",      0,4'd0,8'h00, 0,8'h00, 1,4'd2,4'd6, 0,4'd0, 0,8'h00, 4'd4,4'd5, 8'h00,8'hA5,1,1));
    vecs.push_back(mk("ret2WithWe",  1,4'd6,8'h66, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 1,8'hD2, 4'd4,4'd5, 8'h00,8'hA5,1,0));
    vecs.push_back(mk("chk2and6",    0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd2,4'd6, 8'hD2,8'h66,0,0));
    vecs.push_back(mk("prioImm",     1,4'd3,8'h12, 1,8'h5A, 1,4'd5,4'd3, 0,4'd0, 0,8'h00, 4'd4,4'd5, 8'h00,8'hA5,0,0));
    vecs.push_back(mk("prioCopy",    1,4'd4,8'h34, 0,8'h00, 1,4'd3,4'd4, 0,4'd0, 0,8'h00, 4'd3,4'd5, 8'h5A,8'hA5,0,0));
    vecs.push_back(mk("chk4",        0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd4,4'd3, 8'h5A,8'h5A,0,0));
    vecs.push_back(mk("issue3",      0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 1,4'd3, 0,8'h00, 4'd4,4'd5, 8'h5A,8'hA5,0,0));
    vecs.push_back(mk("prioLoad",    1,4'd3,8'h13, 1,8'h42, 0,4'd0,4'd0, 0,4'd0, 1,8'h81, 4'd4,4'd5, 8'h5A,8'hA5,1,0));
    vecs.push_back(mk("chk3",        0,4'd0,8'h00, 0,8'h00, 0,4'd0,4'd0, 0,4'd0, 0,8'h00, 4'd3,4'd5, 8'h81,8'hA5,0,0));

    // Initial reset for two cycles.
    v = idleVec("init");
    v.rst = 1'b1;
    applyStimulus(v);
    applyStimulus(v);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll0(vecs[i]);
    end

    // Reset in the middle of a load, together with a write that must be lost.
    v = idleVec("s1Issue"); v.li = 1; v.ld = 4'd9; v.ra = 4'd5;
    applyStimulus(v);
    checkOutput("s1Issue.A", outA0, 8'hA5);
    v = idleVec("s1Reset"); v.rst = 1; v.we = 1; v.wa = 4'd5; v.wd = 8'hBB;
    applyStimulus(v);
    checkOutput("s1Reset.Busy", {7'd0, busy0}, 8'h01);
    v = idleVec("s1After"); v.ra = 4'd9; v.rb = 4'd5;
    applyStimulus(v);
    checkOutput("s1After.Busy", {7'd0, busy0}, 8'h00);
    checkOutput("s1After.Stall", {7'd0, stall0}, 8'h00);
    checkOutput("s1After.B", outB0, 8'h00);
    v = idleVec("s1IdleRet"); v.lv = 1; v.lvd = 8'hF0; v.ra = 4'd9;
    applyStimulus(v);
    checkOutput("s1IdleRet.Busy", {7'd0, busy0}, 8'h00);
    v = idleVec("s1Chk"); v.ra = 4'd9; v.rb = 4'd0;
    applyStimulus(v);
    checkOutput("s1Chk.A", outA0, 8'h00);
    checkOutput("s1Chk.Busy", {7'd0, busy0}, 8'h00);

    // Same-cycle write and read of r4.
    v = idleVec("byp"); v.we = 1; v.wa = 4'd4; v.wd = 8'h77; v.rb = 4'd4;
    applyStimulus(v);
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp.B", outB0, 8'h77);
`else
    checkOutput("byp.B", outB0, 8'h00);
`endif
    v = idleVec("bypNext"); v.rb = 4'd4;
    applyStimulus(v);
    checkOutput("bypNext.B", outB0, 8'h77);

    // r0 behaviour: writable in dut0, hard-wired zero in dut1.
    v = idleVec("r0Wr"); v.we = 1; v.wa = 4'd0; v.wd = 8'hFF; v.ra = 4'd5;
    applyStimulus(v);
    v = idleVec("r0Rd"); v.ra = 4'd0;
    applyStimulus(v);
    checkOutput("r0Rd.A0", outA0, 8'hFF);
    checkOutput("r0Rd.A1", outA1, 8'h00);
    v = idleVec("r0Issue"); v.li = 1; v.ld = 4'd0; v.ra = 4'd5; v.rb = 4'd6;
    applyStimulus(v);
    v = idleVec("r0Pend"); v.ra = 4'd5; v.rb = 4'd6;
    applyStimulus(v);
    checkOutput("r0Pend.Busy1", {7'd0, busy1}, 8'h01);
    checkOutput("r0Pend.Stall1", {7'd0, stall1}, 8'h00);
    v = idleVec("r0Ret"); v.lv = 1; v.lvd = 8'hAB; v.ra = 4'd5; v.rb = 4'd6;
    applyStimulus(v);
    v = idleVec("r0Chk"); v.ra = 4'd0; v.rb = 4'd0;
    applyStimulus(v);
    checkOutput("r0Chk.A0", outA0, 8'hAB);
    checkOutput("r0Chk.A1", outA1, 8'h00);
    checkOutput("r0Chk.B1", outB1, 8'h00);
    checkOutput("r0Chk.Busy1", {7'd0, busy1}, 8'h00);

    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter W, default 8, data width in bits.
REQ-002 The block SHALL have parameter A, default 4, address width; depth 2**A registers.
REQ-003 The block SHALL have parameter IMM_REG, default 3, destination register of immediate loads.
REQ-004 The block SHALL have parameter ZERO_R0, default 0; when 1, r0 reads as zero and ignores writes.
REQ-005 The block SHALL have port Clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port Reset, input, 1, reset, synchronous, active-high.
REQ-007 The block SHALL have ports RaddrA and RaddrB, input, A, read addresses.
REQ-008 The block SHALL have ports DataOutA and DataOutB, output, W, combinational read data.
REQ-009 The block SHALL have ports WriteEn (input, 1), Waddr (input, A) and DataIn (input, W), the ALU write port.
REQ-010 The block SHALL have ports ImmEn (input, 1) and ImmData (input, W), the immediate write to IMM_REG.
REQ-011 The block SHALL have ports CopyEn (input, 1), CopySrc (input, A) and CopyDst (input, A), the register-to-register move.
REQ-012 The block SHALL have ports LdIssue (input, 1) and LdDst (input, A), the load issue.
REQ-013 The block SHALL have ports LdValid (input, 1) and LdData (input, W), the memory return.
REQ-014 The block SHALL have ports Busy (output, 1), a load outstanding, and Stall (output, 1), a hazard on a pending register.

Function
REQ-015 Reads SHALL be combinational: DataOutX = Registers[RaddrX], with r0 forced to 0 when ZERO_R0=1.
REQ-016 All writes SHALL commit on the rising Clk edge; a copy SHALL take its source value from before that edge.
REQ-017 For same-cycle writes to the same register, priority SHALL be load return > immediate > copy > WriteEn; writes to different registers all commit.
REQ-018 The scoreboard SHALL be FSM IDLE/PEND holding a pending destination pdst.
REQ-019 In IDLE, LdIssue SHALL capture pdst=LdDst and move to PEND on the next cycle; Busy=1 in PEND only.
REQ-020 In PEND, LdValid SHALL write LdData to pdst and return to IDLE, unless LdIssue is accepted in the same cycle, in which case the block stays in PEND with the new pdst.
REQ-021 LdValid in IDLE SHALL be ignored, with no write.
REQ-022 In PEND, Stall SHALL equal (RaddrA==pdst | RaddrB==pdst | (WriteEn & Waddr==pdst) | (CopyEn & (CopySrc==pdst | CopyDst==pdst)) | (ImmEn & IMM_REG==pdst) | LdIssue) & ~LdValid.
REQ-023 While Stall=1, WriteEn, ImmEn, CopyEn and LdIssue SHALL be suppressed; the LdValid return still commits.
REQ-024 A load to r0 with ZERO_R0=1 SHALL still occupy the scoreboard, and its return data SHALL be discarded.

Reset
REQ-025 Reset SHALL clear all registers to 0, force IDLE, clear pdst to 0, and drive Busy=0 and Stall=0 in the following cycle.
REQ-026 Reset asserted mid-load SHALL abandon the load; a later LdValid is handled as in IDLE (REQ-021).
REQ-027 Reset SHALL take priority over every write in the same cycle.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL, when defined, forward the priority-resolved same-cycle write data to any read port whose address matches the destination; a load return does not produce Stall in that cycle.
REQ-029 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge register value; there is no forwarding logic.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the scoreboard state enum (IDLE, PEND) and the default W/A/IMM_REG constants.
REQ-031 The scoreboard SHALL be the sub-module regfile_scoreboard, producing Busy, Stall and pdst; the storage array and write muxing SHALL stay in reg_file_sb.

Verification
REQ-032 The bench SHALL check: Reset, then WriteEn Waddr=5 DataIn=8'hA5 -> next cycle DataOutA(RaddrA=5)=8'hA5, and Reset mid-run returns it to 0.
REQ-033 The bench SHALL check: ImmEn ImmData=8'h3C together with WriteEn Waddr=3 DataIn=8'h11 -> r3=8'h3C; CopyEn Src=3 Dst=1 in the next cycle -> r1=8'h3C.
REQ-034 The bench SHALL check: LdIssue LdDst=7, then RaddrA=7 -> Stall=1 and Busy=1; LdValid LdData=8'h5E two cycles later -> r7=8'h5E, then Busy=0 and Stall=0.
REQ-035 The bench SHALL check: in PEND with pdst=7, LdValid and LdIssue LdDst=2 in the same cycle -> r7 written, FSM stays in PEND with pdst=2.
REQ-036 The bench SHALL check: ZERO_R0=1, WriteEn Waddr=0 DataIn=8'hFF -> DataOutA(RaddrA=0)=0; LdValid in IDLE -> no register changes.
REQ-037 The bench SHALL check with REGFILE_BYPASS_EN: WriteEn Waddr=4 DataIn=8'h77 and RaddrB=4 in the same cycle -> DataOutB=8'h77 combinationally; without the macro -> the old value.
